// File: rtl/me_block_scheduler_pkg.sv
// Shared ME definitions: sequencer state encoding, motion-vector width and
// the default search-window centre, plus the index-to-MV conversion.
package me_block_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_RUN    = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } me_state_e;

  localparam int MV_W              = 6;
  localparam int SEARCH_OFFSET_DEF = 8;

  // Zero-extend a 5-bit search index and subtract the window centre in
  // MV_W-bit two's complement.
  function automatic logic [MV_W-1:0] idx_to_mv(input logic [4:0] idx,
                                                input int         offset);
    return {1'b0, idx} - MV_W'(offset);
  endfunction

endpackage

// File: rtl/me_blk_counter.sv
// Raster-order block position counter: x runs across a row, then y steps.
// The position returns to (0,0) after the last block of the frame.
module me_blk_counter #(
  parameter int W_BLK = 8,
  parameter int H_BLK = 8,
  parameter int XW    = 3,
  parameter int YW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);

  logic row_end;

  // Flags for the end of a row and the final block of the frame.
  always_comb begin
    row_end = (x == XW'(W_BLK - 1));
    last    = row_end && (y == YW'(H_BLK - 1));
  end

  // Position register: cleared on reset or frame start, stepped on advance.
  always_ff @(posedge clk) begin
    // NOTE: state in clocked processes uses <= so every flop samples the
    // pre-edge values, independent of statement order.
    if (rst || clr) begin
      x <= '0;
      y <= '0;
    end else if (adv) begin
      if (row_end) begin
        x <= '0;
        y <= last ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/me_block_scheduler.sv
// Frame-level ME sequencer: launches one ME run per block in raster order,
// captures each block's MSAD and best position as a signed motion vector,
// and offers the result downstream over valid/ready.
module me_block_scheduler
  import me_block_scheduler_pkg::*;
#(
  parameter int FRAME_W_BLK    = 8,
  parameter int FRAME_H_BLK    = 8,
  parameter int SAD_BIT_WIDTH  = 14,
  parameter int SEARCH_OFFSET  = SEARCH_OFFSET_DEF,
  parameter int TIMEOUT_CYCLES = 512,
  localparam int XW = (FRAME_W_BLK > 1) ? $clog2(FRAME_W_BLK) : 1,
  localparam int YW = (FRAME_H_BLK > 1) ? $clog2(FRAME_H_BLK) : 1,
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic                     core_start_o,
  output logic                     core_en_o,
  output logic [XW-1:0]            blk_x_o,
  output logic [YW-1:0]            blk_y_o,
  input  logic                     core_valid_i,
  input  logic [SAD_BIT_WIDTH-1:0] core_msad_i,
  input  logic [4:0]               core_col_i,
  input  logic [4:0]               core_row_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [SAD_BIT_WIDTH-1:0] res_msad_o,
  output logic [MV_W-1:0]          res_mvx_o,
  output logic [MV_W-1:0]          res_mvy_o,
  output logic [XW-1:0]            res_blk_x_o,
  output logic [YW-1:0]            res_blk_y_o
);

  me_state_e state, state_nxt;
  logic [TW-1:0] tcnt;
  logic          start_acc;
  logic          transfer;
  logic          capture;
  logic          tmo_last;
  logic          timeout_hit;
  logic          last_blk;

  // Raster position of the block currently being processed.
  me_blk_counter #(
    .W_BLK (FRAME_W_BLK),
    .H_BLK (FRAME_H_BLK),
    .XW    (XW),
    .YW    (YW)
  ) u_blk_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_acc),
    .adv  (transfer),
    .x    (blk_x_o),
    .y    (blk_y_o),
    .last (last_blk)
  );

  // Qualified events derived from state and handshake inputs.
  always_comb begin
    start_acc   = (state == ST_IDLE) && start_i;
    transfer    = (state == ST_HOLD) && res_ready_i;
    capture     = (state == ST_RUN) && core_valid_i;
    tmo_last    = (tcnt == TW'(TIMEOUT_CYCLES - 1));
    timeout_hit = (state == ST_RUN) && !core_valid_i && tmo_last;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a valid in the timeout cycle takes priority.
  always_comb begin
    // NOTE: defaulting every combinational output first means no path can
    // leave it unassigned, so no latch is inferred.
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (start_i) state_nxt = ST_LAUNCH;
      ST_LAUNCH: state_nxt = ST_RUN;
      ST_RUN: begin
        if (core_valid_i)  state_nxt = ST_HOLD;
        else if (tmo_last) state_nxt = ST_DONE;
      end
      ST_HOLD:   if (res_ready_i) state_nxt = last_blk ? ST_DONE : ST_LAUNCH;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    busy_o       = (state != ST_IDLE);
    done_o       = (state == ST_DONE);
    core_start_o = (state == ST_LAUNCH);
    core_en_o    = (state == ST_RUN);
    res_valid_o  = (state == ST_HOLD);
  end

  // Cycles spent in RUN for the current block; zero on entry to RUN.
  always_ff @(posedge clk) begin
    if (rst)                  tcnt <= '0;
    else if (state == ST_RUN) tcnt <= tcnt + 1'b1;
    else                      tcnt <= '0;
  end

  // Sticky timeout flag, cleared when a new frame is accepted.
  always_ff @(posedge clk) begin
    if (rst || start_acc) err_o <= 1'b0;
    else if (timeout_hit) err_o <= 1'b1;
  end

  // Result register, loaded only when the core reports during RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_msad_o  <= '0;
      res_mvx_o   <= '0;
      res_mvy_o   <= '0;
      res_blk_x_o <= '0;
      res_blk_y_o <= '0;
    end else if (capture) begin
      res_msad_o  <= core_msad_i;
      res_mvx_o   <= idx_to_mv(core_col_i, SEARCH_OFFSET);
      res_mvy_o   <= idx_to_mv(core_row_i, SEARCH_OFFSET);
      res_blk_x_o <= blk_x_o;
      res_blk_y_o <= blk_y_o;
    end
  end

endmodule
